// File: rtl/ram_loader.sv
// ---------------------------------------------------------------------------
// ram_loader
//
// Writer side of the microcomputer's program RAM. Accepts DEPTH bytes over a
// valid/ready stream, writes them to addresses 0..DEPTH-1 while keeping a
// running checksum, then reads the whole RAM back and compares checksums.
// The computer is held in clear until a load has been verified.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   start      one-cycle pulse starting a load (IDLE/DONE/ERROR only)
//   data_in    byte to load
//   data_valid data_in is valid
//   data_ready loader can accept a byte this cycle
//   ram_we     RAM write strobe
//   ram_addr   RAM address (write or read)
//   ram_wdata  RAM write data
//   ram_rdata  RAM read data, valid one cycle after ram_addr with ram_we=0
//   cpu_clear  1 = computer held in clear
//   busy       high during LOAD and VERIFY
//   done       verified program present
//   error      readback checksum mismatch
// ---------------------------------------------------------------------------
module ram_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              cpu_clear,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // One extra bit so DEPTH itself is representable and the count never wraps.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_ADDR_C  = CNT_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VERIFY,
    DONE,
    ERROR
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [DATA_W-1:0]  sum_w_reg;
  logic [DATA_W-1:0]  sum_r_reg;

  logic [CNT_W-1:0]   cnt_inc;
  logic [DATA_W-1:0]  sum_r_next;

  assign cnt_inc    = cnt_reg + 1'b1;
  // Carry discarded: checksum is modulo 2**DATA_W.
  assign sum_r_next = sum_r_reg + ram_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      sum_w_reg  <= '0;
      sum_r_reg  <= '0;
      data_ready <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_clear  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state_reg  <= LOAD;
            cnt_reg    <= '0;
            sum_w_reg  <= '0;
            sum_r_reg  <= '0;
            data_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_clear  <= 1'b1;
          end
        end

        LOAD: begin
          ram_we <= 1'b0;
          if (cnt_reg == DEPTH_C) begin
            // Reached only in the cycle carrying the final write strobe;
            // present address 0 straight away so VERIFY reads on its first cycle.
            state_reg  <= VERIFY;
            cnt_reg    <= '0;
            data_ready <= 1'b0;
            ram_addr   <= '0;
          end else if (data_valid && data_ready) begin
            sum_w_reg  <= sum_w_reg + data_in;
            ram_we     <= 1'b1;
            ram_addr   <= cnt_reg[ADDR_W-1:0];
            ram_wdata  <= data_in;
            cnt_reg    <= cnt_inc;
            data_ready <= (cnt_inc < DEPTH_C);
          end
        end

        VERIFY: begin
          // cnt_reg is the cycle index k within VERIFY: address k is on the
          // bus during cycle k and its data is captured at the end of cycle k+1.
          if (cnt_reg != '0) begin
            sum_r_reg <= sum_r_next;
          end
          if (cnt_reg < LAST_ADDR_C) begin
            ram_addr <= cnt_inc[ADDR_W-1:0];
          end
          if (cnt_reg == DEPTH_C) begin
            busy <= 1'b0;
            // Compare against the sum including this cycle's final capture.
            if (sum_r_next == sum_w_reg) begin
              state_reg <= DONE;
              done      <= 1'b1;
              cpu_clear <= 1'b0;
            end else begin
              state_reg <= ERROR;
              error     <= 1'b1;
              cpu_clear <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_inc;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Program loader for the 8-bit microcomputer. It is the writer side of the 16x8 main program RAM, which the computer only ever reads.
- Accepts a stream of bytes over a valid/ready handshake and writes them to RAM addresses 0..DEPTH-1.
- Reads every byte back and checks an 8-bit running checksum.
- Holds the computer in clear until a verified program is present.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM word width.
- DEPTH, 16, number of words loaded; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; everything updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- data_in  input  DATA_W  byte to load.
- data_valid  input  1  data_in is valid.
- data_ready  output  1  loader can accept a byte this cycle.
- ram_we  output  1  RAM write strobe, one cycle per word.
- ram_addr  output  ADDR_W  RAM address for write or read.
- ram_wdata  output  DATA_W  RAM write data.
- ram_rdata  input  DATA_W  RAM read data; valid one cycle after ram_addr is presented with ram_we=0.
- cpu_clear  output  1  holds the computer in clear; 1 = held.
- busy  output  1  high in LOAD and VERIFY.
- done  output  1  verified program present.
- error  output  1  verify mismatch.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; word counter, sum_w and sum_r cleared to 0.
  - Outputs: data_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, busy=0, done=0, error=0, cpu_clear=1.
  - Reset overrides start and every other input in the same cycle. Reset mid-LOAD or mid-VERIFY abandons the operation; RAM contents are left as they are.
- All outputs are registered.
- IDLE:
  - cpu_clear=1.
  - On start: go to LOAD; clear counter, sum_w and sum_r; done=0, error=0.
- LOAD:
  - busy=1; data_ready=1 while counter < DEPTH.
  - A beat is accepted when data_valid and data_ready are both high.
  - On each accepted beat:
    - sum_w <= sum_w + data_in, mod 256.
    - Next cycle: ram_we=1, ram_addr=counter, ram_wdata=data_in.
    - Counter increments.
  - Write latency is 1 cycle after accept. Gaps in data_valid produce no write. Back-to-back beats give one write per cycle.
  - data_ready drops in the cycle after the DEPTH-th accept; data_valid is ignored from then on.
  - After the last write strobe, go to VERIFY with the counter cleared.
- VERIFY:
  - ram_we=0. Present ram_addr = 0..DEPTH-1 on consecutive cycles.
  - Capture ram_rdata one cycle after each address: sum_r <= sum_r + ram_rdata, mod 256.
  - Takes DEPTH+1 cycles, including the final capture.
  - After the last capture, compare sum_r with sum_w:
    - equal: go to DONE.
    - unequal: go to ERROR.
- DONE:
  - done=1, cpu_clear=0, busy=0.
  - Held until start or reset.
- ERROR:
  - error=1, cpu_clear=1, busy=0.
  - Held until start or reset.
- Restart: start in DONE or ERROR behaves as in IDLE. cpu_clear returns to 1 in the same cycle that LOAD is entered.
- start while busy is ignored: no restart, no counter change.
- Counter wrap: the counter is ADDR_W+1 bits, so DEPTH itself is representable and the counter never wraps. ram_addr is the low ADDR_W bits.
- Checksum arithmetic: DATA_W-bit unsigned, carry discarded.

Test Plan:
- Reset, then start, then 16 back-to-back beats data_in=0x10..0x1F.
  - Expect writes to addresses 0..15 with matching data, each 1 cycle after accept.
  - sum_w=0x78. VERIFY reads back 0x78; done=1, cpu_clear=0, error=0.
- Same load with data_valid toggling every other cycle.
  - Expect exactly 16 ram_we pulses, no write in gap cycles, same final done=1.
- RAM model corrupts address 5 on readback (returns 0x00 instead of 0x15).
  - Expect sum_r=0x63 versus sum_w=0x78; error=1, done=0, cpu_clear stays 1.
- Reset asserted after 7 accepted beats.
  - Next cycle: state IDLE, all outputs at reset values, no further ram_we.
  - A fresh start then loads 16 new bytes from address 0.
- start pulsed during LOAD beat 3 and during VERIFY.
  - Counter and sums are unaffected; the load completes normally.
- From DONE, start with bytes 0xFF x16.
  - cpu_clear=1 immediately; sum_w = 0xF0; done=1 again after verify.
